// File: rtl/hl_btn_conditioner.sv
// hl_btn_conditioner
//
// Conditions raw active-low pushbuttons into clean, active-high events. Each channel is fully
// independent:
//   raw btn_n -> 2-flop synchronizer -> debounce (level accepted after DEBOUNCE_CYCLES
//   consecutive differing samples) -> edge pulses -> hold timer (long press after LONG_CYCLES).
//
// Ports
//   clk            system clock, rising edge
//   rst_n          asynchronous active-low reset
//   btn_n          [N_BTN] raw pushbuttons, active-low, asynchronous to clk
//   btn_level      [N_BTN] debounced level, 1 = pressed
//   press_pulse    [N_BTN] one-cycle pulse in the first cycle btn_level reads 1
//   release_pulse  [N_BTN] one-cycle pulse in the first cycle btn_level reads 0
//   long_pulse     [N_BTN] one-cycle pulse LONG_CYCLES cycles after press_pulse, once per press
//
// Bit order for the default four channels: 0 mode, 1 echo, 2 noise, 3 filter.

module hl_btn_conditioner #(
    parameter int unsigned N_BTN           = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned LONG_CYCLES     = 50000000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_BTN-1:0] btn_n,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] press_pulse,
    output logic [N_BTN-1:0] release_pulse,
    output logic [N_BTN-1:0] long_pulse
);

    localparam int unsigned DebW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned LongW = $clog2(LONG_CYCLES + 1);

    // Counter value seen in the last differing cycle before the level is accepted.
    localparam logic [DebW-1:0]  DebLast  = DebW'(DEBOUNCE_CYCLES - 1);
    // Hold count that, on the next held edge, reaches the long-press threshold.
    localparam logic [LongW-1:0] LongLast = LongW'(LONG_CYCLES - 1);
    localparam logic [LongW-1:0] LongMax  = LongW'(LONG_CYCLES);

    for (genvar i = 0; i < N_BTN; i++) begin : g_chan

        // ------------------------------------------------------------------
        // Synchronizer: resets to 1 so a reset looks like "released".
        // ------------------------------------------------------------------
        logic sync1_q, sync2_q;
        logic sample;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sync1_q <= 1'b1;
                sync2_q <= 1'b1;
            end else begin
                sync1_q <= btn_n[i];
                sync2_q <= sync1_q;
            end
        end

        assign sample = ~sync2_q;

        // ------------------------------------------------------------------
        // Debounce, edge pulses and hold timer.
        // ------------------------------------------------------------------
        logic [DebW-1:0]  deb_cnt_q, deb_cnt_d;
        logic [LongW-1:0] hold_cnt_q, hold_cnt_d;
        logic             level_q, level_d;
        logic             press_q, press_d;
        logic             release_q, release_d;
        logic             long_q, long_d;
        logic             differ;
        logic             deb_done;
        logic             held;

        always_comb begin
            differ   = (sample != level_q);
            // Accept the new level once the sample has differed for DEBOUNCE_CYCLES cycles.
            deb_done = differ && (deb_cnt_q == DebLast);

            if (!differ || deb_done) begin
                deb_cnt_d = '0;
            end else begin
                deb_cnt_d = deb_cnt_q + 1'b1;
            end

            level_d   = deb_done ? sample : level_q;
            press_d   = deb_done && sample;
            release_d = deb_done && !sample;

            // Counting only while pressed before and after this edge keeps the press cycle at
            // zero and lets a release in the threshold cycle win over the long pulse.
            held = level_q && level_d;

            if (!held) begin
                hold_cnt_d = '0;
            end else if (hold_cnt_q == LongMax) begin
                hold_cnt_d = hold_cnt_q;
            end else begin
                hold_cnt_d = hold_cnt_q + 1'b1;
            end

            // Saturation guarantees LongLast is passed only once per press.
            long_d = held && (hold_cnt_q == LongLast);
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                deb_cnt_q  <= '0;
                hold_cnt_q <= '0;
                level_q    <= 1'b0;
                press_q    <= 1'b0;
                release_q  <= 1'b0;
                long_q     <= 1'b0;
            end else begin
                deb_cnt_q  <= deb_cnt_d;
                hold_cnt_q <= hold_cnt_d;
                level_q    <= level_d;
                press_q    <= press_d;
                release_q  <= release_d;
                long_q     <= long_d;
            end
        end

        assign btn_level[i]     = level_q;
        assign press_pulse[i]   = press_q;
        assign release_pulse[i] = release_q;
        assign long_pulse[i]    = long_q;
    end

endmodule

// File: tb/tb_hl_btn_conditioner.sv
module tb_hl_btn_conditioner;

    localparam int unsigned NB  = 4;
    localparam int unsigned DEB = 4;
    localparam int unsigned LNG = 10;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b1;
    logic [NB-1:0] btn_n = '1;
    logic [NB-1:0] btn_level, press_pulse, release_pulse, long_pulse;

    always #5 clk = ~clk;

    hl_btn_conditioner #(
        .N_BTN           (NB),
        .DEBOUNCE_CYCLES (DEB),
        .LONG_CYCLES     (LNG)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .btn_n         (btn_n),
        .btn_level     (btn_level),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .long_pulse    (long_pulse)
    );

    typedef struct {
        int unsigned   cyc;
        logic [NB-1:0] pr;
        logic [NB-1:0] rl;
        logic [NB-1:0] lg;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    // ---------------------------------------------------------------
    // Reference model: the level flips when the last DEB synchronized
    // samples all disagree with it; a long press is reported LNG edges
    // after the press edge if the level never dropped in between.
    // ---------------------------------------------------------------
    int unsigned   cyc = 0;
    logic [NB-1:0] raw_dly[$];
    logic [NB-1:0] samp_hist[$];
    logic [NB-1:0] m_level = '0;
    int unsigned   press_cyc[NB];
    bit            long_armed[NB];

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                raw_dly.delete();
                raw_dly.push_back('1);
                raw_dly.push_back('1);
                samp_hist.delete();
                exp_q.delete();
                m_level = '0;
                for (int c = 0; c < NB; c++) long_armed[c] = 1'b0;
            end else begin
                logic [NB-1:0] samp, pr, rl, lg;
                exp_t          e;
                cyc++;
                samp = ~raw_dly.pop_front();
                raw_dly.push_back(btn_n);
                samp_hist.push_back(samp);
                if (samp_hist.size() > DEB) void'(samp_hist.pop_front());
                pr = '0; rl = '0; lg = '0;
                for (int c = 0; c < NB; c++) begin
                    bit flip;
                    flip = (samp_hist.size() == DEB);
                    foreach (samp_hist[k]) if (samp_hist[k][c] == m_level[c]) flip = 1'b0;
                    if (flip) begin
                        m_level[c] = ~m_level[c];
                        if (m_level[c]) begin
                            pr[c]         = 1'b1;
                            press_cyc[c]  = cyc;
                            long_armed[c] = 1'b1;
                        end else begin
                            rl[c]         = 1'b1;
                            long_armed[c] = 1'b0;
                        end
                    end else if (m_level[c] && long_armed[c] && (cyc - press_cyc[c] == LNG)) begin
                        lg[c]         = 1'b1;
                        long_armed[c] = 1'b0;
                    end
                end
                if ((pr | rl | lg) != '0) begin
                    e.cyc = cyc; e.pr = pr; e.rl = rl; e.lg = lg;
                    exp_q.push_back(e);
                end
            end
        end
    end

    // ---------------------------------------------------------------
    // Monitor: samples on the falling edge, pops expected events.
    // ---------------------------------------------------------------
    initial begin
        forever begin
            logic [NB-1:0] any;
            exp_t          e;
            @(negedge clk);
            while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                e = exp_q.pop_front();
                checks++;
                failures++;
                $display("FAIL missed_event cyc=%0d got=none required pr=%b rl=%b lg=%b",
                         e.cyc, e.pr, e.rl, e.lg);
            end
            checks++;
            if (btn_level !== m_level) begin
                failures++;
                $display("FAIL btn_level cyc=%0d got=%b required=%b", cyc, btn_level, m_level);
            end
            checks++;
            if (((press_pulse & release_pulse) | (press_pulse & long_pulse) |
                 (release_pulse & long_pulse)) !== '0) begin
                failures++;
                $display("FAIL exclusive_pulses cyc=%0d got pr=%b rl=%b lg=%b required=disjoint",
                         cyc, press_pulse, release_pulse, long_pulse);
            end
            any = press_pulse | release_pulse | long_pulse;
            if (any != '0 || (exp_q.size() > 0 && exp_q[0].cyc == cyc)) begin
                checks++;
                if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
                    e = exp_q.pop_front();
                    if (press_pulse !== e.pr || release_pulse !== e.rl || long_pulse !== e.lg) begin
                        failures++;
                        $display("FAIL pulses cyc=%0d got pr=%b rl=%b lg=%b required pr=%b rl=%b lg=%b",
                                 cyc, press_pulse, release_pulse, long_pulse, e.pr, e.rl, e.lg);
                    end
                end else begin
                    failures++;
                    $display("FAIL unexpected_pulse cyc=%0d got pr=%b rl=%b lg=%b required=none",
                             cyc, press_pulse, release_pulse, long_pulse);
                end
            end
        end
    end

    // ---------------------------------------------------------------
    // Stimulus
    // ---------------------------------------------------------------
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_zero(input string name);
        checks++;
        if ({btn_level, press_pulse, release_pulse, long_pulse} !== '0) begin
            failures++;
            $display("FAIL %s got lvl=%b pr=%b rl=%b lg=%b required=all zero",
                     name, btn_level, press_pulse, release_pulse, long_pulse);
        end
    endtask

    // Asserts reset between edges so outputs of the last edge were already observed.
    task automatic do_reset(input string name, input int low_cycles);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1 check_zero(name);
        step(low_cycles);
        rst_n = 1'b1;
    endtask

    int unsigned run_left[NB];

    initial begin
        #2 rst_n = 1'b0;
        #1 check_zero("power_on_reset");
        step(2);
        rst_n = 1'b1;
        step(3);

        // Clean press and release on channel 0.
        btn_n[0] = 1'b0; step(12);
        btn_n[0] = 1'b1; step(12);

        // Bounce on channel 1, then settle pressed.
        for (int k = 0; k < 4; k++) begin
            btn_n[1] = k[0]; step(3);
        end
        btn_n[1] = 1'b0; step(12);
        btn_n[1] = 1'b1; step(12);

        // Long press on channel 2: held 20 cycles beyond the press.
        btn_n[2] = 1'b0; step(6 + 20);
        btn_n[2] = 1'b1; step(12);

        // Channel 3 released so release lands 9 cycles after the press.
        btn_n[3] = 1'b0; step(9);
        btn_n[3] = 1'b1; step(16);

        // Release exactly in the long-threshold cycle (release wins).
        btn_n[2] = 1'b0; step(10);
        btn_n[2] = 1'b1; step(14);

        // All channels together.
        btn_n = '0; step(8);
        btn_n = '1; step(12);

        // Reset in the middle of a debounce, button kept held through it.
        btn_n[0] = 1'b0; step(5);
        do_reset("reset_mid_debounce", 2);
        step(12);
        btn_n[0] = 1'b1; step(12);

        // Reset in the middle of a hold, level already high.
        btn_n[2] = 1'b0; step(10);
        do_reset("reset_mid_hold", 3);
        btn_n[2] = 1'b1; step(12);

        // Randomized run lengths: glitches, clean presses and long holds mixed.
        for (int c = 0; c < NB; c++) run_left[c] = 0;
        for (int i = 0; i < 800; i++) begin
            if (i == 400) do_reset("reset_random", 2);
            for (int c = 0; c < NB; c++) begin
                if (run_left[c] == 0) begin
                    btn_n[c]    = ~btn_n[c];
                    run_left[c] = $urandom_range(1, 24);
                end
                run_left[c]--;
            end
            step(1);
        end
        btn_n = '1;
        step(30);

        while (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            checks++;
            failures++;
            $display("FAIL missed_event_at_end cyc=%0d got=none required pr=%b rl=%b lg=%b",
                     e.cyc, e.pr, e.rl, e.lg);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
